// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiplier controller.
package vedic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} vmul_state_t;

  localparam int DIGIT_W = 2;

  function automatic int digit_cnt(input int width);
    return width / DIGIT_W;
  endfunction

endpackage

// File: rtl/vedic_mult_2bit.sv
// 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier cell: vertical and crosswise partial terms.
module vedic_mult_2bit (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);

  logic hi_term;
  logic cross_a;
  logic cross_b;
  logic carry1;

  assign hi_term = a_i[1] & b_i[1];
  assign cross_a = a_i[1] & b_i[0];
  assign cross_b = a_i[0] & b_i[1];
  assign carry1  = cross_a & cross_b;

  assign p_o[0] = a_i[0] & b_i[0];
  assign p_o[1] = cross_a ^ cross_b;
  assign p_o[2] = hi_term ^ carry1;
  assign p_o[3] = hi_term & carry1;

endmodule

// File: rtl/vedic_seq_mult_ctrl.sv
// Iterative WIDTH x WIDTH multiplier reusing one 2x2 Vedic cell over all digit pairs.
// Optional signed operands when VEDIC_SEQ_SIGNED_EN is defined (adds is_signed_i).
module vedic_seq_mult_ctrl
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef VEDIC_SEQ_SIGNED_EN
  input  logic               is_signed_i,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);

  localparam int D  = digit_cnt(WIDTH);
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(PW) + 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  vmul_state_t       state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d;
  logic              neg_q, neg_d;

  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              neg_in;
  logic [1:0]        a_dig, b_dig;
  logic [3:0]        pp;
  logic [SW-1:0]     shamt;
  logic [PW-1:0]     acc_sum;

  // Latch magnitudes so the unsigned datapath serves both modes; sign is reapplied at the end.
`ifdef VEDIC_SEQ_SIGNED_EN
  assign a_mag  = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag  = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign neg_in = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
`else
  assign a_mag  = a_i;
  assign b_mag  = b_i;
  assign neg_in = 1'b0;
`endif

  assign a_dig = 2'(a_q >> {i_q, 1'b0});
  assign b_dig = 2'(b_q >> {j_q, 1'b0});

  vedic_mult_2bit u_cell (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_o (pp)
  );

  assign shamt   = SW'(i_q) + SW'(j_q);
  assign acc_sum = acc_q + (PW'(pp) << {shamt, 1'b0});

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = neg_in;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            prod_d  = neg_q ? -acc_sum : acc_sum;
            state_d = DONE;
          end else begin
            i_d = CW'(i_q + 1'b1);
          end
        end else begin
          j_d = CW'(j_q + 1'b1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy_o    = (state_q != IDLE);
  assign product_o = prod_q;

endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Self-checking bench: WIDTH=8 vector table + random ops, reset abort, WIDTH=4 full sweep.
module tb_vedic_seq_mult_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        in_valid, in_ready, out_valid, out_ready, busy, is_signed;
  logic [7:0]  a_i, b_i;
  logic [15:0] product;

  // WIDTH=4 instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4, is_signed4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  vedic_seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i),
`ifdef VEDIC_SEQ_SIGNED_EN
    .is_signed_i(is_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .product_o(product), .busy_o(busy)
  );

  vedic_seq_mult_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a_i(a4), .b_i(b4),
`ifdef VEDIC_SEQ_SIGNED_EN
    .is_signed_i(is_signed4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .product_o(product4), .busy_o(busy4)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication of the (optionally signed) operand values.
  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int sa, sb;
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    return 16'(sa * sb);
  endfunction

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
    int          hold;
    logic        poke;
  } vec_t;

  vec_t vecs[$];

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                         input logic [15:0] exp, input int hold, input logic poke,
                         input string name);
    int   guard;
    int   lat;
    logic saw_rdy;
    logic [15:0] held;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
    a_i = a; b_i = b; is_signed = sgn; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; saw_rdy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) saw_rdy = 1'b1;
      if (poke) begin
        in_valid = 1'b1; a_i = ~a; b_i = 8'h5A;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({name, " latency"}, 32'(lat), 32'd16);
    check({name, " in_ready_low_run"}, 32'(saw_rdy), 32'd0);
    check({name, " product"}, 32'(product), 32'(exp));
    check({name, " busy_done"}, 32'(busy), 32'd1);
    held = product;
    for (int h = 0; h < hold; h++) begin
      in_valid = poke; a_i = 8'h11; b_i = 8'h22;
      @(negedge clk);
      check($sformatf("%s hold%0d valid", name, h), 32'(out_valid), 32'd1);
      check($sformatf("%s hold%0d product", name, h), 32'(product), 32'(held));
      check($sformatf("%s hold%0d in_ready", name, h), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid_cleared"}, 32'(out_valid), 32'd0);
    check({name, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b);
    int lat;
    logic [7:0] exp;
    exp = 8'(int'(a) * int'(b));
    @(negedge clk);
    check($sformatf("w4 %0h*%0h in_ready", a, b), 32'(in_ready4), 32'd1);
    a4 = a; b4 = b; in_valid4 = 1'b1; out_ready4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("w4 %0h*%0h latency", a, b), 32'(lat), 32'd4);
    check($sformatf("w4 %0h*%0h product", a, b), 32'(product4), 32'(exp));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int         off;
    in_valid = 0; out_ready = 0; a_i = 0; b_i = 0; is_signed = 0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; is_signed4 = 0;
    rst_n = 1'b0;
    #23;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{a: 8'hFF, b: 8'hFF, sgn: 1'b0, exp: 16'hFE01, hold: 0, poke: 1'b0});
    vecs.push_back('{a: 8'h00, b: 8'hA5, sgn: 1'b0, exp: 16'h0000, hold: 0, poke: 1'b0});
    vecs.push_back('{a: 8'h01, b: 8'hC3, sgn: 1'b0, exp: 16'h00C3, hold: 0, poke: 1'b0});
    vecs.push_back('{a: 8'h37, b: 8'h2B, sgn: 1'b0, exp: 16'h093D, hold: 5, poke: 1'b1});
`ifdef VEDIC_SEQ_SIGNED_EN
    vecs.push_back('{a: 8'h80, b: 8'h80, sgn: 1'b1, exp: 16'h4000, hold: 1, poke: 1'b0});
    vecs.push_back('{a: 8'hFD, b: 8'h05, sgn: 1'b1, exp: 16'hFFF1, hold: 0, poke: 1'b0});
    vecs.push_back('{a: 8'hFD, b: 8'h05, sgn: 1'b0, exp: 16'h04F1, hold: 0, poke: 1'b0});
`endif
    foreach (vecs[k])
      run_op8(vecs[k].a, vecs[k].b, vecs[k].sgn, vecs[k].exp, vecs[k].hold, vecs[k].poke,
              $sformatf("vec%0d", k));

    // Reset in the middle of RUN aborts to reset values without waiting for a clock edge.
    @(negedge clk);
    a_i = 8'hFF; b_i = 8'h11; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(8'h12, 8'h34, 1'b0, 16'h03A8, 0, 1'b0, "post_reset");

    for (int r = 0; r < 20; r++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
`ifdef VEDIC_SEQ_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op8(ra, rb, rs, model8(ra, rb, rs), int'($urandom_range(0, 2)), 1'($urandom),
              $sformatf("rand%0d", r));
    end

    // Full WIDTH=4 sweep in a randomized (bijective) order.
    off = int'($urandom_range(0, 255));
    for (int k = 0; k < 256; k++) begin
      int idx;
      idx = (k * 167 + off) % 256;
      run_op4(4'(idx >> 4), 4'(idx));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
